// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - next-PC arbitration, pipeline flush strobes and BTB invalidate sweep
// Optional BTB sweep compiled in with BTB_FLUSH_EN; otherwise flush requests are acked immediately.
module fetch_redirect_ctrl #(
    parameter int BTB_DEPTH = 512,
    parameter int IDX_W     = 9,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      pc_plus_4,
    input  logic             predict_taken,
    input  logic [31:0]      predict_pc,
    input  logic             mispredict,
    input  logic [31:0]      mispredict_pc,
    input  logic             trap,
    input  logic [31:0]      trap_vector,
    input  logic             btb_flush_req,
    output logic             btb_flush_ack,
    output logic             pc_enable,
    output logic [31:0]      next_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             dbp_off,
    output logic             btb_clr_valid,
    output logic [IDX_W-1:0] btb_clr_idx,
    output logic [CNT_W-1:0] mispredict_cnt
);

    typedef enum logic [1:0] {RUN, POST, CLEAR, ACK} state_t;

    state_t state;
    logic   redirect;
    logic   mispredict_win;
    logic   ack_d;
    logic   req_ok;

    assign redirect       = trap | mispredict;
    assign mispredict_win = mispredict & ~trap;
    // A request still high right after an ack belongs to the sweep just finished.
    assign req_ok         = btb_flush_req & ~btb_flush_ack & ~ack_d;

    always_comb begin
        next_pc = pc_plus_4;
        if (trap) begin
            next_pc = trap_vector;
        end else if (mispredict) begin
            next_pc = mispredict_pc;
        end else if (state == RUN && predict_taken) begin
            next_pc = predict_pc;
        end
    end

    assign pc_enable  = redirect | (~stall & (state == RUN || state == POST));
    assign flush_ifid = redirect;
    assign flush_idex = redirect;
    assign dbp_off    = (state != RUN);

`ifdef BTB_FLUSH_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BTB_DEPTH - 1);

    logic [IDX_W-1:0] clr_idx;

    assign btb_clr_valid = (state == CLEAR);
    assign btb_clr_idx   = clr_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            clr_idx        <= '0;
            btb_flush_ack  <= 1'b0;
            ack_d          <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            ack_d         <= btb_flush_ack;
            btb_flush_ack <= 1'b0;
            if (mispredict_win && mispredict_cnt != {CNT_W{1'b1}}) begin
                mispredict_cnt <= mispredict_cnt + 1'b1;
            end
            case (state)
                RUN: begin
                    if (redirect) begin
                        state <= POST;
                    end else if (req_ok) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                POST: state <= redirect ? POST : RUN;
                // Redirects during the sweep are serviced by the comb path; the sweep itself never pauses.
                CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state         <= ACK;
                        btb_flush_ack <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                ACK: state <= redirect ? POST : RUN;
                default: state <= RUN;
            endcase
        end
    end
`else
    assign btb_clr_valid = 1'b0;
    assign btb_clr_idx   = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            btb_flush_ack  <= 1'b0;
            ack_d          <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            ack_d         <= btb_flush_ack;
            btb_flush_ack <= (state == RUN) & ~redirect & req_ok;
            if (mispredict_win && mispredict_cnt != {CNT_W{1'b1}}) begin
                mispredict_cnt <= mispredict_cnt + 1'b1;
            end
            state <= redirect ? POST : RUN;
        end
    end
`endif

endmodule
